// File: rtl/cnt_arb_pkg.sv
// Shared types for the counter command arbiter.
// Command encoding, FSM states and field widths.
package cnt_arb_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [1:0] {
    CMD_READ = 2'b00,
    CMD_UP   = 2'b01,
    CMD_DOWN = 2'b10,
    CMD_LOAD = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/cnt_cmd_arbiter_if.sv
// Requester, response and counter-side bundle for cnt_cmd_arbiter.
// slave = arbiter side, master = client/counter side.
interface cnt_cmd_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 5
);

  logic [N_REQ-1:0]         i_req_valid;
  logic [2*N_REQ-1:0]       i_req_cmd;
  logic [N_REQ*DW-1:0]      i_req_data;
  logic [N_REQ-1:0]         o_req_ready;
  logic                     o_rsp_valid;
  logic                     i_rsp_ready;
  logic [$clog2(N_REQ)-1:0] o_rsp_id;
  logic [DW-1:0]            o_rsp_value;
  logic                     o_rsp_sat;
  logic [DW-1:0]            o_cnt_in;
  logic                     o_cnt_load;
  logic                     o_cnt_up;
  logic                     o_cnt_down;
  logic [DW-1:0]            i_cnt_value;
  logic                     i_cnt_high;
  logic                     i_cnt_low;

  modport slave (
    input  i_req_valid, i_req_cmd, i_req_data,
    input  i_rsp_ready,
    input  i_cnt_value, i_cnt_high, i_cnt_low,
    output o_req_ready,
    output o_rsp_valid, o_rsp_id,
    output o_rsp_value, o_rsp_sat,
    output o_cnt_in, o_cnt_load,
    output o_cnt_up, o_cnt_down
  );

  modport master (
    output i_req_valid, i_req_cmd, i_req_data,
    output i_rsp_ready,
    output i_cnt_value, i_cnt_high, i_cnt_low,
    input  o_req_ready,
    input  o_rsp_valid, o_rsp_id,
    input  o_rsp_value, o_rsp_sat,
    input  o_cnt_in, o_cnt_load,
    input  o_cnt_up, o_cnt_down
  );

endinterface

// File: rtl/cnt_rr_arbiter.sv
// One-hot grant + index from a request vector.
// Round-robin by default; CNT_ARB_FIXED_PRI_EN selects lowest-index-wins.
module cnt_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     advance,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     gnt_valid
);

  localparam int IDW = $clog2(N_REQ);

`ifdef CNT_ARB_FIXED_PRI_EN

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_idx   = IDW'(i);
        gnt_valid = 1'b1;
      end
    end
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

`else

  logic [IDW-1:0] ptr_q, ptr_d;

  always_comb begin
    int k;
    k         = 0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!gnt_valid && req[k]) begin
        gnt_idx   = IDW'(k);
        gnt_valid = 1'b1;
      end
    end
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && gnt_valid) begin
      ptr_d = (int'(gnt_idx) == N_REQ - 1)
            ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

`endif

endmodule

// File: rtl/cnt_cmd_arbiter.sv
// Shares one saturating up/down counter among N_REQ requesters.
// Arbitration mode: CNT_ARB_FIXED_PRI_EN (see cnt_rr_arbiter).
module cnt_cmd_arbiter
  import cnt_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  cnt_cmd_arbiter_if.slave bus
);

  localparam int ID_WIDTH = $clog2(N_REQ);
  localparam int DW       = DATA_WIDTH;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  cmd_e                cmd_q, cmd_d;
  logic [DW-1:0]       data_q, data_d;
  logic [DW-1:0]       val_q, val_d;
  logic                sat_q, sat_d;
  logic                rv_q, rv_d;

  logic [N_REQ-1:0]    gnt;
  logic [ID_WIDTH-1:0] gnt_idx;
  logic                gnt_valid;
  logic                advance;
  logic                ld, up, dn;

  cnt_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .req       (bus.i_req_valid),
    .advance   (advance),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    val_d   = val_q;
    sat_d   = sat_q;
    rv_d    = rv_q;
    advance = 1'b0;
    bus.o_req_ready = '0;
    ld = 1'b0;
    up = 1'b0;
    dn = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          advance = 1'b1;
          bus.o_req_ready = gnt;
          id_d    = gnt_idx;
          cmd_d   = cmd_e'(bus.i_req_cmd[gnt_idx*CMD_W +: CMD_W]);
          data_d  = bus.i_req_data[gnt_idx*DW +: DW];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ld = (cmd_q == CMD_LOAD);
        up = (cmd_q == CMD_UP);
        dn = (cmd_q == CMD_DOWN);
        // strobe goes out even when saturated; the counter just holds
        sat_d = (up && bus.i_cnt_high) || (dn && bus.i_cnt_low);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        val_d   = bus.i_cnt_value;
        rv_d    = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.i_rsp_ready) begin
          rv_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      cmd_q   <= CMD_READ;
      data_q  <= '0;
      val_q   <= '0;
      sat_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      val_q   <= val_d;
      sat_q   <= sat_d;
      rv_q    <= rv_d;
    end
  end

  assign bus.o_rsp_valid = rv_q;
  assign bus.o_rsp_id    = id_q;
  assign bus.o_rsp_value = val_q;
  assign bus.o_rsp_sat   = sat_q;
  assign bus.o_cnt_in    = data_q;
  assign bus.o_cnt_load  = ld;
  assign bus.o_cnt_up    = up;
  assign bus.o_cnt_down  = dn;

endmodule

// File: tb/tb_cnt_cmd_arbiter.sv
// Self-checking bench for cnt_cmd_arbiter with a saturating counter.
// Honours CNT_ARB_FIXED_PRI_EN in its grant model.
module tb_cnt_cmd_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cnt_cmd_arbiter_if #(.N_REQ(4), .DW(5)) bus ();

  cnt_cmd_arbiter #(.N_REQ(4), .DATA_WIDTH(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [4:0] cnt;
  logic       preset_en;
  logic [4:0] preset_v;

  always @(posedge clk) begin
    if (preset_en)                    cnt <= preset_v;
    else if (bus.o_cnt_load)          cnt <= bus.o_cnt_in;
    else if (bus.o_cnt_up && cnt != 5'd31) cnt <= cnt + 5'd1;
    else if (bus.o_cnt_down && cnt != 5'd0) cnt <= cnt - 5'd1;
  end

  assign bus.i_cnt_value = cnt;
  assign bus.i_cnt_high  = (cnt == 5'd31);
  assign bus.i_cnt_low   = (cnt == 5'd0);

  int total = 0;
  int bad   = 0;
  int mcnt  = 0;
  int ptr   = 0;
  int last_wait = 0;
  int obs_id, obs_val, obs_sat;

  typedef struct {
    int id;
    int cmd;
    int data;
    int pre;
    int exp_val;
    int exp_sat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] m);
`ifdef CNT_ARB_FIXED_PRI_EN
    for (int i = 0; i < 4; i++) if (m[i]) return i;
`else
    for (int i = 0; i < 4; i++) if (m[(ptr + i) % 4]) return (ptr + i) % 4;
`endif
    return -1;
  endfunction

  function automatic int strobes();
    return {29'd0, bus.o_cnt_load, bus.o_cnt_up, bus.o_cnt_down};
  endfunction

  task automatic preset(input int v);
    preset_en = 1'b1;
    preset_v  = 5'(v);
    @(negedge clk);
    preset_en = 1'b0;
    mcnt = v;
  endtask

  task automatic run_txn(input logic [3:0] mask, input logic [7:0] cmds,
                         input logic [19:0] datas, input int delay,
                         input bit hold);
    int g, w, ev, es, estb;
    logic [1:0] c;
    logic [4:0] d;
    bus.i_req_valid = mask;
    bus.i_req_cmd   = cmds;
    bus.i_req_data  = datas;
    bus.i_rsp_ready = 1'b0;
    #1;
    w = 0;
    while (bus.o_req_ready == 4'd0 && w < 8) begin
      @(negedge clk); #1; w++;
    end
    last_wait = w;
    if (bus.o_req_ready == 4'd0) begin
      check("accept_timeout", 0, 1);
      bus.i_req_valid = '0;
      return;
    end
    g = pick(mask);
    check("grant", int'(bus.o_req_ready), 1 << g);
    c = cmds[2*g +: 2];
    d = datas[5*g +: 5];
    es = 0;
    case (c)
      2'b00: begin ev = mcnt; estb = 0; end
      2'b01: begin es = (mcnt == 31) ? 1 : 0; ev = es ? mcnt : mcnt + 1; estb = 2; end
      2'b10: begin es = (mcnt == 0) ? 1 : 0; ev = es ? mcnt : mcnt - 1; estb = 1; end
      default: begin ev = int'(d); estb = 4; end
    endcase
    mcnt = ev;
    ptr  = (g + 1) % 4;
    @(negedge clk);
    bus.i_req_valid = hold ? mask : 4'd0;
    #1;
    check("strobe", strobes(), estb);
    check("ready_busy", int'(bus.o_req_ready), 0);
    if (c == 2'b11) check("cnt_in", int'(bus.o_cnt_in), int'(d));
    w = 0;
    do begin
      @(negedge clk); #1; w++;
      if (!bus.o_rsp_valid) check("strobe_idle", strobes(), 0);
    end while (!bus.o_rsp_valid && w < 6);
    if (!bus.o_rsp_valid) begin
      check("rsp_timeout", 0, 1);
      bus.i_req_valid = '0;
      return;
    end
    obs_id  = int'(bus.o_rsp_id);
    obs_val = int'(bus.o_rsp_value);
    obs_sat = int'(bus.o_rsp_sat);
    check("rsp_id", obs_id, g);
    check("rsp_value", obs_val, ev);
    check("rsp_sat", obs_sat, es);
    for (int s = 0; s < delay; s++) begin
      @(negedge clk); #1;
      check("stall_valid", int'(bus.o_rsp_valid), 1);
      check("stall_id", int'(bus.o_rsp_id), g);
      check("stall_value", int'(bus.o_rsp_value), ev);
      check("stall_sat", int'(bus.o_rsp_sat), es);
      check("stall_ready", int'(bus.o_req_ready), 0);
      check("stall_strobe", strobes(), 0);
    end
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    bus.i_rsp_ready = 1'b0;
    #1;
    check("rsp_cleared", int'(bus.o_rsp_valid), 0);
  endtask

  int exp_ord[5];

  initial begin
    vecs[0] = '{2, 3, 17,  0, 17, 0};
    vecs[1] = '{0, 1,  0, 31, 31, 1};
    vecs[2] = '{1, 2,  0,  0,  0, 1};
    vecs[3] = '{3, 0,  0,  9,  9, 0};
    vecs[4] = '{1, 1,  0,  5,  6, 0};
    vecs[5] = '{2, 2,  0, 10,  9, 0};
    vecs[6] = '{0, 3, 31,  4, 31, 0};
    vecs[7] = '{3, 1,  0, 30, 31, 0};
    vecs[8] = '{1, 3,  0, 12,  0, 0};
`ifdef CNT_ARB_FIXED_PRI_EN
    exp_ord = '{0, 0, 0, 0, 0};
`else
    exp_ord = '{0, 1, 2, 3, 0};
`endif

    rst_n = 1'b0;
    preset_en = 1'b1;
    preset_v  = 5'd3;
    bus.i_req_valid = '0;
    bus.i_req_cmd   = '0;
    bus.i_req_data  = '0;
    bus.i_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", int'(bus.o_rsp_valid), 0);
    check("rst_ready", int'(bus.o_req_ready), 0);
    check("rst_strobe", strobes(), 0);
    check("rst_cnt_in", int'(bus.o_cnt_in), 0);
    rst_n = 1'b1;
    preset_en = 1'b0;
    mcnt = 3;
    @(negedge clk);

    // reset while a LOAD is in ISSUE
    bus.i_req_valid = 4'b0010;
    bus.i_req_cmd   = 8'b0000_1100;
    bus.i_req_data  = 20'(20 << 5);
    #1;
    check("midrst_grant", int'(bus.o_req_ready), 2);
    @(negedge clk);
    bus.i_req_valid = '0;
    #1;
    check("midrst_issue", strobes(), 4);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", int'(bus.o_req_ready), 0);
    check("midrst_strobe", strobes(), 0);
    check("midrst_rsp_valid", int'(bus.o_rsp_valid), 0);
    check("midrst_rsp_id", int'(bus.o_rsp_id), 0);
    check("midrst_rsp_value", int'(bus.o_rsp_value), 0);
    check("midrst_rsp_sat", int'(bus.o_rsp_sat), 0);
    check("midrst_cnt_in", int'(bus.o_cnt_in), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr = 0;
    @(negedge clk);
    #1;
    check("midrst_cnt_kept", int'(cnt), 3);
    check("midrst_no_rsp", int'(bus.o_rsp_valid), 0);
    @(negedge clk);

    // all four requesting UP continuously from zero
    preset(0);
    for (int j = 0; j < 5; j++) begin
      run_txn(4'hF, 8'b0101_0101, 20'($urandom), 0, 1'b1);
      check("allup_id", obs_id, exp_ord[j]);
      check("allup_val", obs_val, j + 1);
    end
    bus.i_req_valid = '0;
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      preset(vecs[v].pre);
      run_txn(4'(1 << vecs[v].id),
              8'($urandom) & ~8'(3 << (2*vecs[v].id)) | 8'(vecs[v].cmd << (2*vecs[v].id)),
              20'($urandom) & ~20'(31 << (5*vecs[v].id)) | 20'(vecs[v].data << (5*vecs[v].id)),
              0, 1'b0);
      check("vec_id", obs_id, vecs[v].id);
      check("vec_val", obs_val, vecs[v].exp_val);
      check("vec_sat", obs_sat, vecs[v].exp_sat);
    end

    // response stall with other requesters waiting
    preset(7);
    run_txn(4'b0110, 8'b0101_0101, 20'd0, 5, 1'b1);
    run_txn(4'b0110, 8'b0101_0101, 20'd0, 0, 1'b0);
    check("regrant_wait", last_wait, 0);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 4) == 0) begin
        bus.i_req_valid = '0;
        preset($urandom_range(0, 1) == 1 ? 31 : 0);
      end
      run_txn(4'($urandom_range(1, 15)), 8'($urandom), 20'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    bus.i_req_valid = '0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
